instr_fetch: RTL and testbench

Instruction fetch unit; the requesting end of the instruction `memory_rom` read interface. It drives the ROM word address and collects the instruction returned one clock later. A 2-entry buffer absorbs that latency, and the unit presents PC/instruction pairs to decode over a valid/ready handshake. It handles branch/jump redirects and a fetch halt, and sits between the PC logic and the decode stage of the MIPS core.

---
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the ROM word address, absorbs the 1-cycle ROM latency in a
// 2-entry {pc, instr} FIFO, and hands instructions to decode over valid/ready.
// Optional stall counter output perf_stall_cycles is built when IFETCH_PERF_CNT_EN is defined.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  entry_t      fifo [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic [31:0] target;
  logic        deq;
  logic        push;
  logic        run_now;
  logic        issue;
  logic [2:0]  occ;

  assign target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    rom_addr = pc;
    if (redirect_valid) rom_addr = target;
    else if (!rst_n)    rom_addr = RESET_PC_AL;
  end

  assign out_valid = (count != 2'd0) && !redirect_valid;
  assign out_pc    = fifo[rd_ptr].pc;
  assign out_instr = fifo[rd_ptr].instr;
  assign deq       = out_valid && out_ready;
  assign push      = inflight && !redirect_valid;

  // Both states resolve from this cycle's halt: RUN stops issuing the cycle halt rises,
  // HALT resumes issuing the cycle halt falls.
  always_comb begin
    run_now = 1'b0;
    case (state)
      RUN:     run_now = !halt;
      HALT:    run_now = !halt;
      default: run_now = 1'b0;
    endcase
  end

  // Entries held or owed once this cycle's transfer is taken out.
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
  assign issue = rst_n && run_now && (redirect_valid || (occ < 3'd2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC_AL;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else begin
      state    <= halt ? HALT : RUN;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= rom_addr;
        pc          <= rom_addr + 32'd4;
      end else if (redirect_valid) begin
        pc <= target;
      end
      if (redirect_valid) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= '{pc: inflight_pc, instr: rom_rdata};
          wr_ptr       <= ~wr_ptr;
        end
        if (deq) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, deq};
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      perf_stall_cycles <= '0;
    else if (out_valid && !out_ready && (perf_stall_cycles != 32'hFFFF_FFFF))
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-cycle vector table for stream/backpressure/redirect/halt/reset,
// plus a hand sequence on a second instance with RESET_PC near the top of the address space.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_ready;

  logic [31:0] rom_addr, rom_rdata, out_instr, out_pc;
  logic        out_valid;
  logic [31:0] rom_addr2, rom_rdata2, out_instr2, out_pc2;
  logic        out_valid2;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf, perf2;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef IFETCH_PERF_CNT_EN
    , .perf_stall_cycles(perf)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr2), .rom_rdata(rom_rdata2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2)
`ifdef IFETCH_PERF_CNT_EN
    , .perf_stall_cycles(perf2)
`endif
  );

  // ROM contents: word i holds 0x1000_0000 + i, read data one cycle after the address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    rom_rdata  <= rom_word(rom_addr);
    rom_rdata2 <= rom_word(rom_addr2);
  end

  typedef struct {
    logic        rst_n, rdy, halt, rv;
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic h, input logic rv,
                     input logic [31:0] rpc, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.rdy = rdy; v.halt = h; v.rv = rv; v.rpc = rpc;
    v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic h, input logic rv,
                       input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst_n = r; out_ready = rdy; halt = h; redirect_valid = rv; redirect_pc = rpc;
    #2;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    //   rst rdy hlt rv  rpc            addr           vld pc
    add(0, 1, 0, 0, 32'h0,   32'h00,  0, 32'h00); // c0 reset
    add(1, 1, 0, 0, 32'h0,   32'h00,  0, 32'h00); // c1 first issue
    add(1, 1, 0, 0, 32'h0,   32'h04,  0, 32'h00);
    add(1, 1, 0, 0, 32'h0,   32'h08,  1, 32'h00); // c3 first instruction
    add(1, 1, 0, 0, 32'h0,   32'h0C,  1, 32'h04);
    add(1, 0, 0, 0, 32'h0,   32'h10,  1, 32'h08); // c5..c9 backpressure
    add(1, 0, 0, 0, 32'h0,   32'h10,  1, 32'h08);
    add(1, 0, 0, 0, 32'h0,   32'h10,  1, 32'h08);
    add(1, 0, 0, 0, 32'h0,   32'h10,  1, 32'h08);
    add(1, 0, 0, 0, 32'h0,   32'h10,  1, 32'h08);
    add(1, 1, 0, 0, 32'h0,   32'h10,  1, 32'h08); // c10 release
    add(1, 1, 0, 0, 32'h0,   32'h14,  1, 32'h0C);
    add(1, 1, 0, 0, 32'h0,   32'h18,  1, 32'h10);
    add(1, 1, 0, 1, 32'h43,  32'h40,  0, 32'h00); // c13 redirect
    add(1, 1, 0, 0, 32'h0,   32'h44,  0, 32'h00);
    add(1, 1, 0, 0, 32'h0,   32'h48,  1, 32'h40);
    add(1, 1, 0, 0, 32'h0,   32'h4C,  1, 32'h44);
    add(1, 1, 1, 0, 32'h0,   32'h50,  1, 32'h48); // c17..c20 halt
    add(1, 1, 1, 0, 32'h0,   32'h50,  1, 32'h4C);
    add(1, 1, 1, 0, 32'h0,   32'h50,  0, 32'h00);
    add(1, 1, 1, 0, 32'h0,   32'h50,  0, 32'h00);
    add(1, 1, 0, 0, 32'h0,   32'h50,  0, 32'h00); // c21 resume
    add(1, 1, 0, 0, 32'h0,   32'h54,  0, 32'h00);
    add(1, 1, 0, 0, 32'h0,   32'h58,  1, 32'h50);
    add(1, 1, 0, 0, 32'h0,   32'h5C,  1, 32'h54);
    add(1, 0, 0, 0, 32'h0,   32'h60,  1, 32'h58); // c25 fill two entries
    add(1, 0, 0, 0, 32'h0,   32'h60,  1, 32'h58);
    add(0, 0, 0, 0, 32'h0,   32'h00,  1, 32'h58); // c27 mid-stream reset
    add(1, 1, 0, 0, 32'h0,   32'h00,  0, 32'h00);
    add(1, 1, 0, 0, 32'h0,   32'h04,  0, 32'h00);
    add(1, 1, 0, 0, 32'h0,   32'h08,  1, 32'h00);
    add(1, 1, 0, 0, 32'h0,   32'h0C,  1, 32'h04);
    add(1, 1, 1, 1, 32'h200, 32'h200, 0, 32'h00); // c32 halt + redirect
    add(1, 1, 0, 0, 32'h0,   32'h200, 0, 32'h00);
    add(1, 1, 0, 0, 32'h0,   32'h204, 0, 32'h00);
    add(1, 1, 0, 0, 32'h0,   32'h208, 1, 32'h200);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].rdy, vecs[i].halt, vecs[i].rv, vecs[i].rpc);
      chk("rom_addr", i, rom_addr, vecs[i].exp_addr);
      chk("out_valid", i, {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk("out_pc", i, out_pc, vecs[i].exp_pc);
        chk("out_instr", i, out_instr, rom_word(vecs[i].exp_pc));
      end
`ifdef IFETCH_PERF_CNT_EN
      if (i == 10) chk("perf_stall", i, perf, 32'd5);
      if (i == 27) chk("perf_stall", i, perf, 32'd7);
      if (i == 28) chk("perf_stall", i, perf, 32'd0);
`endif
    end

    // Reset values, then wrap of the sequential PC on the second instance.
    drive(0, 1, 0, 0, 32'h0);
    chk("wrap rom_addr rst", 100, rom_addr2, 32'hFFFF_FFF8);
    drive(1, 1, 0, 0, 32'h0);
    chk("rst out_valid", 101, {31'b0, out_valid}, 32'h0);
    chk("rst out_pc", 101, out_pc, 32'h0);
    chk("rst out_instr", 101, out_instr, 32'h0);
    chk("wrap rom_addr", 101, rom_addr2, 32'hFFFF_FFF8);
    chk("wrap out_valid", 101, {31'b0, out_valid2}, 32'h0);
    drive(1, 1, 0, 0, 32'h0);
    chk("wrap rom_addr", 102, rom_addr2, 32'hFFFF_FFFC);
    chk("wrap out_valid", 102, {31'b0, out_valid2}, 32'h0);
    drive(1, 1, 0, 0, 32'h0);
    chk("wrap rom_addr", 103, rom_addr2, 32'h0000_0000);
    chk("wrap out_valid", 103, {31'b0, out_valid2}, 32'h1);
    chk("wrap out_pc", 103, out_pc2, 32'hFFFF_FFF8);
    chk("wrap out_instr", 103, out_instr2, 32'h4FFF_FFFE);
    drive(1, 1, 0, 0, 32'h0);
    chk("wrap out_valid", 104, {31'b0, out_valid2}, 32'h1);
    chk("wrap out_pc", 104, out_pc2, 32'hFFFF_FFFC);
    chk("wrap out_instr", 104, out_instr2, 32'h4FFF_FFFF);
    drive(1, 1, 0, 0, 32'h0);
    chk("wrap out_valid", 105, {31'b0, out_valid2}, 32'h1);
    chk("wrap out_pc", 105, out_pc2, 32'h0000_0000);
    chk("wrap out_instr", 105, out_instr2, 32'h1000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
